wbu_branch: RTL and testbench
=============================

# wbu_branch

Writeback and branch-resolution stage placed directly after the execute unit. Accepts one executed instruction per valid/ready handshake and decodes the execute unit's result word, including the three-way compare code (0 = equal, 32'b10 = greater, 32'b100 = less). Produces a one-cycle GPR write pulse and hands the next PC to the fetch side over a second valid/ready handshake. A retire counter tracks completed instructions.

## Interface
- RESET_PC, 32'h8000_0000, value of `npc` after reset
- CNT_WIDTH, 32, width of `retire_cnt`
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- ex_valid  in  1  execute result present
- ex_ready  out  1  stage can accept this cycle
- ex_data  in  32  execute unit result or compare code
- ex_pc  in  32  PC of the instruction
- ex_target  in  32  branch/jump target, precomputed upstream
- ex_rd  in  5  destination register index
- ex_op  in  3  0 nop, 1 alu-write, 2 set-less, 3 jal/jalr, 4 beq, 5 bne, 6 blt, 7 bge
- gpr_wen  out  1  GPR write strobe, one cycle
- gpr_waddr  out  5  GPR write index
- gpr_wdata  out  32  GPR write data
- npc_valid  out  1  next PC offered to fetch
- npc_ready  in  1  fetch takes next PC
- npc  out  32  next PC
- bad_code  out  1  one-cycle pulse: compare code not in {0, 2, 4} on ops 2, 4-7
- retire_cnt  out  CNT_WIDTH  count of accepted instructions

## Operation
- FSM: IDLE, SEND. Handshake fires when `ex_valid & ex_ready`.
- `ex_ready` = (state == IDLE) | (state == SEND & npc_ready); combinational.
- IDLE + fire -> SEND. SEND + npc_ready + fire -> SEND with new data. SEND + npc_ready + no fire -> IDLE. SEND + !npc_ready -> SEND, all outputs held.
- Write data per op: 1 -> ex_data; 2 -> 1 if ex_data == 32'b100, else 0; 3 -> ex_pc + 4. Ops 0, 4-7 never write.
- `gpr_wen` = 1 only for ops 1-3 with ex_rd != 0; rd 0 silently dropped. `gpr_waddr` and `gpr_wdata` register on every fire, regardless of wen.
- Next PC: op 3 -> ex_target. Op 4 taken if code == 0. Op 5 taken if code != 0. Op 6 taken if code == 32'b100. Op 7 taken if code is 0 or 32'b10. Taken -> ex_target, else ex_pc + 4. Ops 0-2 -> ex_pc + 4. All adds are mod 2^32.
- Bad code on branch ops: branch is treated as not taken, `bad_code` pulses, instruction still retires. Bad code on op 2 writes 0 and pulses `bad_code`.
- `retire_cnt` increments by 1 on every fire and wraps from all-ones to 0.

## Timing
- Reset (rst_n low at edge) sets: state IDLE, gpr_wen 0, gpr_waddr 0, gpr_wdata 0, npc_valid 0, npc RESET_PC, bad_code 0, retire_cnt 0. Reset wins over a simultaneous fire; an in-flight npc is discarded.
- Fire at edge N: gpr_wen, bad_code, npc and npc_valid are valid during cycle N+1. gpr_wen and bad_code are high for exactly one cycle per fire. Back-to-back fires give consecutive pulses.
- npc_valid stays high until npc_ready is sampled high. npc is stable while npc_valid is high and npc_ready is low.
- Throughput is one instruction per cycle when npc_ready is held high. No combinational path from ex_* to any output; the only combinational path is npc_ready -> ex_ready.

## Test plan
- Reset, then op 1, rd 5, data 0x1234 with npc_ready=1 -> next cycle: gpr_wen=1, waddr 5, wdata 0x1234, npc = pc+4, retire_cnt 1.
- beq at pc 0x80000010, target 0x80000100, code 0 -> npc 0x80000100. Repeat with code 2 -> npc 0x80000014. blt with code 4 -> taken. bge with code 4 -> not taken.
- jal, rd 1, pc 0x80000000 -> wdata 0x80000004, npc = target. Same with rd 0 -> gpr_wen stays 0, npc still updated.
- npc_ready held 0 for 3 cycles after a fire -> ex_ready=0 and npc stable. Raise npc_ready together with ex_valid -> new fire that cycle, npc updates next cycle, no bubble.
- Branch op with code 0x8 -> bad_code pulses once, npc = pc+4, retire_cnt increments.
- Preload retire_cnt to all-ones via 2^CNT_WIDTH-1 fires (use CNT_WIDTH=4) -> next fire wraps it to 0. Assert rst_n low mid-SEND -> all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/wbu_branch_if.sv
// Handshake bundle between execute, this writeback/branch stage and fetch.
// The slave view belongs to the stage; the master view to its environment.
interface wbu_branch_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_data;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_op;
    logic        npc_valid;
    logic        npc_ready;
    logic [31:0] npc;

    modport slave (
        input  ex_valid, ex_data, ex_pc, ex_target, ex_rd, ex_op, npc_ready,
        output ex_ready, npc_valid, npc
    );

    modport master (
        output ex_valid, ex_data, ex_pc, ex_target, ex_rd, ex_op, npc_ready,
        input  ex_ready, npc_valid, npc
    );
endinterface

// File: rtl/wbu_branch.sv
// Writeback and branch-resolution stage: decodes execute results, pulses GPR
// writes, offers the next PC to fetch and counts retired instructions.
module wbu_branch #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wbu_branch_if.slave          bus,
    output logic                 gpr_wen,
    output logic [4:0]           gpr_waddr,
    output logic [31:0]          gpr_wdata,
    output logic                 bad_code,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    localparam logic [31:0] CODE_EQ = 32'd0;
    localparam logic [31:0] CODE_GT = 32'd2;
    localparam logic [31:0] CODE_LT = 32'd4;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                 w_fire;
    logic                 w_ready;
    logic                 w_eq;
    logic                 w_gt;
    logic                 w_lt;
    logic                 w_code_ok;
    logic                 w_cmp_op;
    logic                 w_bad;
    logic                 w_taken;
    logic                 w_writes;
    logic [31:0]          w_pc4;
    logic [31:0]          w_wdata;
    logic [31:0]          w_npc;

    logic                 r_gpr_wen;
    logic [4:0]           r_gpr_waddr;
    logic [31:0]          r_gpr_wdata;
    logic                 r_bad_code;
    logic [31:0]          r_npc;
    logic [CNT_WIDTH-1:0] r_retire_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ex_ready depends only on state and npc_ready, never on ex_* inputs.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.ex_valid) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                w_ready = bus.npc_ready;
                if (bus.npc_ready) begin
                    w_state_nxt = bus.ex_valid ? S_SEND : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_fire = bus.ex_valid & w_ready;
    end

    always_comb begin
        w_eq      = (bus.ex_data == CODE_EQ);
        w_gt      = (bus.ex_data == CODE_GT);
        w_lt      = (bus.ex_data == CODE_LT);
        w_code_ok = w_eq | w_gt | w_lt;
        w_cmp_op  = (bus.ex_op == 3'd2) | bus.ex_op[2];
        w_bad     = w_cmp_op & ~w_code_ok;
        w_pc4     = bus.ex_pc + 32'd4;

        w_writes  = 1'b0;
        w_wdata   = '0;
        w_taken   = 1'b0;
        case (bus.ex_op)
            3'd1: begin
                w_writes = 1'b1;
                w_wdata  = bus.ex_data;
            end
            3'd2: begin
                w_writes = 1'b1;
                w_wdata  = {31'd0, w_lt};
            end
            3'd3: begin
                w_writes = 1'b1;
                w_wdata  = w_pc4;
                w_taken  = 1'b1;
            end
            // Invalid codes decode to not-taken because each term needs a legal code.
            3'd4:    w_taken = w_eq;
            3'd5:    w_taken = w_gt | w_lt;
            3'd6:    w_taken = w_lt;
            3'd7:    w_taken = w_eq | w_gt;
            default: w_taken = 1'b0;
        endcase
        w_npc = w_taken ? bus.ex_target : w_pc4;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gpr_wen    <= 1'b0;
            r_gpr_waddr  <= '0;
            r_gpr_wdata  <= '0;
            r_bad_code   <= 1'b0;
            r_npc        <= RESET_PC;
            r_retire_cnt <= '0;
        end else begin
            r_gpr_wen  <= w_fire & w_writes & (bus.ex_rd != 5'd0);
            r_bad_code <= w_fire & w_bad;
            if (w_fire) begin
                r_gpr_waddr  <= bus.ex_rd;
                r_gpr_wdata  <= w_wdata;
                r_npc        <= w_npc;
                r_retire_cnt <= r_retire_cnt + CNT_ONE;
            end
        end
    end

    assign bus.ex_ready  = w_ready;
    assign bus.npc_valid = (r_state == S_SEND);
    assign bus.npc       = r_npc;
    assign gpr_wen       = r_gpr_wen;
    assign gpr_waddr     = r_gpr_waddr;
    assign gpr_wdata     = r_gpr_wdata;
    assign bad_code      = r_bad_code;
    assign retire_cnt    = r_retire_cnt;

endmodule

// File: tb/tb_wbu_branch.sv
// Bench for wbu_branch: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of the stage.
module tb_wbu_branch;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic          gpr_wen;
    logic [4:0]    gpr_waddr;
    logic [31:0]   gpr_wdata;
    logic          bad_code;
    logic [CW-1:0] retire_cnt;

    wbu_branch_if bus();

    wbu_branch #(
        .RESET_PC  (32'h8000_0000),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .gpr_wen    (gpr_wen),
        .gpr_waddr  (gpr_waddr),
        .gpr_wdata  (gpr_wdata),
        .bad_code   (bad_code),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model state: what the stage should present after each edge.
    bit          m_send;
    bit          m_wen;
    bit          m_bad;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_npc;
    int unsigned m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Meaning-level decode: the code says eq/gt/lt, each op asks a question of it.
    task automatic ref_decode(input logic [2:0] op, input logic [31:0] code,
                              input logic [31:0] pc, input logic [31:0] tgt,
                              input logic [4:0] rd,
                              output bit wen, output logic [31:0] wdata,
                              output logic [31:0] npc, output bit bad);
        bit eq, gt, lt, legal, taken;
        eq    = (code == 0);
        gt    = (code == 2);
        lt    = (code == 4);
        legal = eq || gt || lt;
        taken = 0;
        wdata = 0;
        wen   = 0;
        bad   = 0;
        case (op)
            1: begin wen = 1; wdata = code; end
            2: begin wen = 1; wdata = (legal && lt) ? 1 : 0; bad = !legal; end
            3: begin wen = 1; wdata = pc + 4; taken = 1; end
            4: begin bad = !legal; taken = legal && eq; end
            5: begin bad = !legal; taken = legal && !eq; end
            6: begin bad = !legal; taken = legal && lt; end
            7: begin bad = !legal; taken = legal && (eq || gt); end
            default: ;
        endcase
        if (rd == 0) wen = 0;
        npc = taken ? tgt : pc + 4;
    endtask

    task automatic drive(input bit v, input logic [2:0] op, input logic [31:0] data,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [4:0] rd, input bit nrdy);
        bus.ex_valid  = v;
        bus.ex_op     = op;
        bus.ex_data   = data;
        bus.ex_pc     = pc;
        bus.ex_target = tgt;
        bus.ex_rd     = rd;
        bus.npc_ready = nrdy;
    endtask

    task automatic cycle();
        bit          exp_ready, fire, wen, bad;
        logic [31:0] wdata, npc;
        #1;
        exp_ready = !m_send || bus.npc_ready;
        check("ex_ready", {31'd0, bus.ex_ready}, {31'd0, exp_ready});
        fire = rst_n && bus.ex_valid && exp_ready;
        ref_decode(bus.ex_op, bus.ex_data, bus.ex_pc, bus.ex_target, bus.ex_rd,
                   wen, wdata, npc, bad);
        @(posedge clk);
        if (!rst_n) begin
            m_send = 0; m_wen = 0; m_bad = 0; m_waddr = 0; m_wdata = 0;
            m_npc = 32'h8000_0000; m_cnt = 0;
        end else if (fire) begin
            m_send = 1; m_wen = wen; m_bad = bad; m_waddr = bus.ex_rd;
            m_wdata = wdata; m_npc = npc; m_cnt = (m_cnt + 1) % (1 << CW);
        end else begin
            m_wen = 0; m_bad = 0;
            if (m_send && bus.npc_ready) m_send = 0;
        end
        #1;
        check("gpr_wen",    {31'd0, gpr_wen},   {31'd0, m_wen});
        check("gpr_waddr",  {27'd0, gpr_waddr}, {27'd0, m_waddr});
        check("gpr_wdata",  gpr_wdata, m_wdata);
        check("npc_valid",  {31'd0, bus.npc_valid}, {31'd0, m_send});
        check("npc",        bus.npc, m_npc);
        check("bad_code",   {31'd0, bad_code},  {31'd0, m_bad});
        check("retire_cnt", {28'd0, retire_cnt}, m_cnt);
    endtask

    logic [31:0] held_npc;
    logic [31:0] r_code;

    initial begin
        m_send = 0; m_wen = 0; m_bad = 0; m_waddr = 0; m_wdata = 0;
        m_npc = 32'h8000_0000; m_cnt = 0;
        rst_n = 1'b0;
        drive(1, 3'd1, 32'h55, 32'h8000_0000, 32'h0, 5'd3, 1);
        cycle();
        cycle();
        check("rst_npc", bus.npc, 32'h8000_0000);
        check("rst_cnt", {28'd0, retire_cnt}, 32'd0);
        rst_n = 1'b1;

        drive(1, 3'd1, 32'h1234, 32'h8000_0000, 32'h0, 5'd5, 1);
        cycle();
        check("alu_wen",   {31'd0, gpr_wen}, 32'd1);
        check("alu_waddr", {27'd0, gpr_waddr}, 32'd5);
        check("alu_wdata", gpr_wdata, 32'h1234);
        check("alu_npc",   bus.npc, 32'h8000_0004);
        check("alu_cnt",   {28'd0, retire_cnt}, 32'd1);

        drive(1, 3'd4, 32'd0, 32'h8000_0010, 32'h8000_0100, 5'd0, 1);
        cycle();
        check("beq_taken", bus.npc, 32'h8000_0100);
        drive(1, 3'd4, 32'd2, 32'h8000_0010, 32'h8000_0100, 5'd0, 1);
        cycle();
        check("beq_not", bus.npc, 32'h8000_0014);
        drive(1, 3'd6, 32'd4, 32'h8000_0010, 32'h8000_0100, 5'd0, 1);
        cycle();
        check("blt_taken", bus.npc, 32'h8000_0100);
        drive(1, 3'd7, 32'd4, 32'h8000_0010, 32'h8000_0100, 5'd0, 1);
        cycle();
        check("bge_not", bus.npc, 32'h8000_0014);

        drive(1, 3'd3, 32'd0, 32'h8000_0000, 32'h8000_0200, 5'd1, 1);
        cycle();
        check("jal_wdata", gpr_wdata, 32'h8000_0004);
        check("jal_npc",   bus.npc, 32'h8000_0200);
        drive(1, 3'd3, 32'd0, 32'h8000_0000, 32'h8000_0300, 5'd0, 1);
        cycle();
        check("jal_rd0_wen", {31'd0, gpr_wen}, 32'd0);
        check("jal_rd0_npc", bus.npc, 32'h8000_0300);

        // Backpressure: fetch stalls three cycles while a new instruction waits.
        drive(1, 3'd1, 32'hABCD, 32'h8000_0040, 32'h0, 5'd7, 1);
        cycle();
        held_npc = bus.npc;
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd1, 32'h9999, 32'h8000_0080, 32'h0, 5'd8, 0);
            cycle();
            check("stall_npc", bus.npc, held_npc);
            check("stall_rdy", {31'd0, bus.ex_ready}, 32'd0);
        end
        drive(1, 3'd1, 32'h9999, 32'h8000_0080, 32'h0, 5'd8, 1);
        cycle();
        check("resume_npc", bus.npc, 32'h8000_0084);
        check("resume_wen", {31'd0, gpr_wen}, 32'd1);

        drive(1, 3'd5, 32'h8, 32'h8000_0020, 32'h8000_0400, 5'd0, 1);
        cycle();
        check("bad_pulse", {31'd0, bad_code}, 32'd1);
        check("bad_npc",   bus.npc, 32'h8000_0024);
        drive(0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1);
        cycle();
        check("bad_once", {31'd0, bad_code}, 32'd0);

        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(1, 3'd0, 32'h0, 32'h1000 + 4 * i, 32'h0, 5'd0, 1);
            cycle();
        end
        check("cnt_full", {28'd0, retire_cnt}, 32'd15);
        drive(1, 3'd0, 32'h0, 32'h2000, 32'h0, 5'd0, 1);
        cycle();
        check("cnt_wrap", {28'd0, retire_cnt}, 32'd0);

        drive(1, 3'd1, 32'h77, 32'h3000, 32'h0, 5'd9, 0);
        cycle();
        rst_n = 1'b0;
        cycle();
        check("midrst_valid", {31'd0, bus.npc_valid}, 32'd0);
        check("midrst_npc",   bus.npc, 32'h8000_0000);
        check("midrst_wen",   {31'd0, gpr_wen}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: r_code = 32'd0;
                1: r_code = 32'd2;
                2: r_code = 32'd4;
                3: r_code = $urandom;
                default: r_code = $urandom_range(0, 7);
            endcase
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), r_code,
                  ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : {$urandom, 2'b00},
                  {$urandom, 2'b00},
                  ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 49) != 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
